// File: rtl/multicycle_ctrl.sv
// Main control unit for the multicycle ARM-subset processor: Moore sequencer for the
// shared datapath plus ALU/flag decode and the raw write requests for conditional logic.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t state, state_next;
    logic   alu_op;
    logic   branch;
    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];
    assign State = state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_next = FETCH;
        unique case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                unique case (Op)
                    2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        unique case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB: RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Only ADD and SUB produce meaningful carry/overflow, so only they update C,V.
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (alu_op) begin
            unique case (cmd)
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
            FlagW[1] = s_bit;
            FlagW[0] = s_bit & ((cmd == 4'b0100) | (cmd == 4'b0010));
        end
    end

    assign PCS = branch | (RegW & (Rd == 4'b1111));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks each instruction class
// through its state sequence and checks state, write requests and ALU decode.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, PCS;
    logic [1:0] ALUSrcB, ResultSrc, FlagW, ALUControl;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .PCS(PCS),
        .FlagW(FlagW), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and park on the following falling edge for sampling.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [3:0] s, input logic regw,
                        input logic memw, input logic pcs);
        check({tag, ".state"}, 32'(State), 32'(s));
        check({tag, ".regw"},  32'(RegW),  32'(regw));
        check({tag, ".memw"},  32'(MemW),  32'(memw));
        check({tag, ".pcs"},   32'(PCS),   32'(pcs));
        tick();
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        Op    = op;
        Funct = funct;
        Rd    = rd;
    endtask

    initial begin
        reset = 1'b1;
        set_instr(2'b01, 6'b000001, 4'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.state",   32'(State),   32'd0);
        check("rst.irwrite", 32'(IRWrite), 32'd1);
        check("rst.nextpc",  32'(NextPC),  32'd1);
        check("rst.regw",    32'(RegW),    32'd0);
        check("rst.memw",    32'(MemW),    32'd0);
        check("rst.pcs",     32'(PCS),     32'd0);
        reset = 1'b0;

        // LDR
        check("ldr.fetch.alusrcb", 32'(ALUSrcB), 32'd2);
        step("ldr", 4'd0, 1'b0, 1'b0, 1'b0);
        step("ldr", 4'd1, 1'b0, 1'b0, 1'b0);
        check("ldr.adr.alusrcb", 32'(ALUSrcB), 32'd1);
        step("ldr", 4'd2, 1'b0, 1'b0, 1'b0);
        check("ldr.rd.adrsrc", 32'(AdrSrc), 32'd1);
        step("ldr", 4'd3, 1'b0, 1'b0, 1'b0);
        check("ldr.wb.resultsrc", 32'(ResultSrc), 32'd1);
        step("ldr", 4'd4, 1'b1, 1'b0, 1'b0);

        // STR
        set_instr(2'b01, 6'b000000, 4'd2);
        step("str", 4'd0, 1'b0, 1'b0, 1'b0);
        step("str", 4'd1, 1'b0, 1'b0, 1'b0);
        step("str", 4'd2, 1'b0, 1'b0, 1'b0);
        check("str.wr.adrsrc", 32'(AdrSrc), 32'd1);
        step("str", 4'd5, 1'b0, 1'b1, 1'b0);

        // ADDS register form, Rd=3
        set_instr(2'b00, 6'b001001, 4'd3);
        check("adds.fetch.flagw", 32'(FlagW), 32'd0);
        step("adds", 4'd0, 1'b0, 1'b0, 1'b0);
        step("adds", 4'd1, 1'b0, 1'b0, 1'b0);
        check("adds.aluctl", 32'(ALUControl), 32'd0);
        check("adds.flagw",  32'(FlagW),      32'd3);
        check("adds.alusrcb", 32'(ALUSrcB),   32'd0);
        step("adds", 4'd6, 1'b0, 1'b0, 1'b0);
        check("adds.wb.resultsrc", 32'(ResultSrc), 32'd0);
        step("adds", 4'd8, 1'b1, 1'b0, 1'b0);

        // ADDS with Rd=15 writes the PC
        set_instr(2'b00, 6'b001001, 4'd15);
        step("addpc", 4'd0, 1'b0, 1'b0, 1'b0);
        step("addpc", 4'd1, 1'b0, 1'b0, 1'b0);
        step("addpc", 4'd6, 1'b0, 1'b0, 1'b0);
        step("addpc", 4'd8, 1'b1, 1'b0, 1'b1);

        // SUBS register form
        set_instr(2'b00, 6'b000101, 4'd4);
        step("subs", 4'd0, 1'b0, 1'b0, 1'b0);
        step("subs", 4'd1, 1'b0, 1'b0, 1'b0);
        check("subs.aluctl", 32'(ALUControl), 32'd1);
        check("subs.flagw",  32'(FlagW),      32'd3);
        step("subs", 4'd6, 1'b0, 1'b0, 1'b0);
        step("subs", 4'd8, 1'b1, 1'b0, 1'b0);

        // ANDS immediate
        set_instr(2'b00, 6'b100001, 4'd3);
        step("ands", 4'd0, 1'b0, 1'b0, 1'b0);
        step("ands", 4'd1, 1'b0, 1'b0, 1'b0);
        check("ands.alusrcb", 32'(ALUSrcB),    32'd1);
        check("ands.aluctl",  32'(ALUControl), 32'd2);
        check("ands.flagw",   32'(FlagW),      32'd2);
        step("ands", 4'd7, 1'b0, 1'b0, 1'b0);
        step("ands", 4'd8, 1'b1, 1'b0, 1'b0);

        // AND immediate without S
        set_instr(2'b00, 6'b100000, 4'd3);
        step("and", 4'd0, 1'b0, 1'b0, 1'b0);
        step("and", 4'd1, 1'b0, 1'b0, 1'b0);
        check("and.aluctl", 32'(ALUControl), 32'd2);
        check("and.flagw",  32'(FlagW),      32'd0);
        step("and", 4'd7, 1'b0, 1'b0, 1'b0);
        step("and", 4'd8, 1'b1, 1'b0, 1'b0);

        // ORRS register form: N,Z only
        set_instr(2'b00, 6'b011001, 4'd5);
        step("orrs", 4'd0, 1'b0, 1'b0, 1'b0);
        step("orrs", 4'd1, 1'b0, 1'b0, 1'b0);
        check("orrs.aluctl", 32'(ALUControl), 32'd3);
        check("orrs.flagw",  32'(FlagW),      32'd2);
        step("orrs", 4'd6, 1'b0, 1'b0, 1'b0);
        step("orrs", 4'd8, 1'b1, 1'b0, 1'b0);

        // Unlisted cmd (EOR 0001) with S: defaults to add, N,Z only
        set_instr(2'b00, 6'b000011, 4'd5);
        step("eors", 4'd0, 1'b0, 1'b0, 1'b0);
        step("eors", 4'd1, 1'b0, 1'b0, 1'b0);
        check("eors.aluctl", 32'(ALUControl), 32'd0);
        check("eors.flagw",  32'(FlagW),      32'd2);
        step("eors", 4'd6, 1'b0, 1'b0, 1'b0);
        step("eors", 4'd8, 1'b1, 1'b0, 1'b0);

        // Branch
        set_instr(2'b10, 6'b000000, 4'd0);
        step("b", 4'd0, 1'b0, 1'b0, 1'b0);
        step("b", 4'd1, 1'b0, 1'b0, 1'b0);
        check("b.alusrcb",   32'(ALUSrcB),   32'd1);
        check("b.resultsrc", 32'(ResultSrc), 32'd2);
        step("b", 4'd9, 1'b0, 1'b0, 1'b1);

        // Undefined
        set_instr(2'b11, 6'b111111, 4'd15);
        step("undef", 4'd0, 1'b0, 1'b0, 1'b0);
        check("undef.dec.flagw", 32'(FlagW), 32'd0);
        step("undef", 4'd1, 1'b0, 1'b0, 1'b0);

        // Reset pulsed during MEMRD abandons the load
        set_instr(2'b01, 6'b000001, 4'd15);
        step("rstmid", 4'd0, 1'b0, 1'b0, 1'b0);
        step("rstmid", 4'd1, 1'b0, 1'b0, 1'b0);
        step("rstmid", 4'd2, 1'b0, 1'b0, 1'b0);
        check("rstmid.memrd.state", 32'(State), 32'd3);
        reset = 1'b1;
        tick();
        check("rstmid.state",   32'(State),   32'd0);
        check("rstmid.regw",    32'(RegW),    32'd0);
        check("rstmid.pcs",     32'(PCS),     32'd0);
        check("rstmid.irwrite", 32'(IRWrite), 32'd1);
        tick();
        check("rstmid.hold.state", 32'(State), 32'd0);
        reset = 1'b0;
        set_instr(2'b11, 6'b000000, 4'd0);
        step("after", 4'd0, 1'b0, 1'b0, 1'b0);
        step("after", 4'd1, 1'b0, 1'b0, 1'b0);
        step("after", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
